flat_bus_serializer: RTL and testbench

FLAT_BUS_SERIALIZER -- requirements
Module: flat_bus_serializer

---
 rtl/flat_bus_serializer.sv | 138 +++++++++++++
 tb/tb_flat_bus_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flat_bus_serializer.sv
// flat_bus_serializer
//   Takes one flat word of NCHUNK chunks (CHUNK_W bits each) over a
//   valid/ready handshake and emits it one chunk per output handshake.
//   The order is most-significant chunk first (MSB_FIRST=1) or
//   least-significant chunk first (MSB_FIRST=0).
//   Once the last chunk handshakes, a new word can be accepted in the
//   same cycle, so back-to-back words stream with no idle cycle.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_flat holds a word
//   in_ready   : block accepts a word this cycle
//   in_flat    : flat word, chunk k = in_flat[k*CHUNK_W +: CHUNK_W]
//   out_valid  : out_chunk is valid
//   out_ready  : downstream accepts the chunk
//   out_chunk  : current chunk
//   out_idx    : emission index of the current chunk (0 = first emitted)
//   out_last   : current chunk is the final chunk of its word
module flat_bus_serializer #(
  parameter int CHUNK_W   = 4,
  parameter int NCHUNK    = 3,
  parameter int MSB_FIRST = 1,
  localparam int FLAT_W   = CHUNK_W * NCHUNK,
  localparam int IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLAT_W-1:0]  in_flat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_chunk,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [FLAT_W-1:0]   word;
  logic [IDX_W-1:0]    sel;
  logic                in_hs;
  logic                out_hs;

  // Pick chunk k of a flat word. A compare loop keeps the select free of
  // variable part-select width arithmetic for any NCHUNK.
  function automatic logic [CHUNK_W-1:0] chunk_at(
    input logic [FLAT_W-1:0] w,
    input logic [IDX_W-1:0]  k
  );
    logic [CHUNK_W-1:0] c;
    c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k == IDX_W'(i)) begin
        c = w[i*CHUNK_W +: CHUNK_W];
      end
    end
    return c;
  endfunction

  // Handshake decode. in_ready opens during the final chunk's handshake
  // so the next word loads on the same edge the current one finishes.
  always_comb begin
    out_valid = (state == SEND);
    out_last  = out_valid && (idx == LAST_IDX);
    out_hs    = out_valid && out_ready;
    in_ready  = (state == IDLE) || (out_hs && out_last);
    in_hs     = in_valid && in_ready;
  end

  // Next-state and index logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (in_hs) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (out_last) begin
            idx_nxt   = '0;
            state_nxt = in_hs ? SEND : IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State / index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Word register: loads only on an accepted word, so in_flat is
  // ignored whenever in_ready is low. Reset clears it so out_chunk
  // reads zero during and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (in_hs) begin
      word <= in_flat;
    end
  end

  // Output select comes only from registered state: no path from in_flat.
  always_comb begin
    sel       = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
    out_chunk = chunk_at(word, sel);
    out_idx   = idx;
  end

endmodule

// File: tb/tb_flat_bus_serializer.sv
// Testbench for flat_bus_serializer. Three instances: MSB-first and
// LSB-first 3x4-bit (sharing stimulus) and a single-chunk 8-bit one.
// A queue-based scoreboard of expected chunks is compared every cycle,
// and directed sequences are pinned against literal chunk lists.
module tb_flat_bus_serializer;

  typedef struct packed {
    logic [7:0] chunk;
    logic [1:0] idx;
    logic       last;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv = 1'b0;
  logic [11:0] flat = '0;
  logic        ordy = 1'b0;
  logic        iv1 = 1'b0;
  logic [7:0]  flat1 = '0;
  logic        ordy1 = 1'b0;

  logic        m_rdy, m_vld, m_last;
  logic [3:0]  m_chunk;
  logic [1:0]  m_idx;
  logic        l_rdy, l_vld, l_last;
  logic [3:0]  l_chunk;
  logic [1:0]  l_idx;
  logic        o_rdy, o_vld, o_last;
  logic [7:0]  o_chunk;
  logic [0:0]  o_idx;

  int checks = 0;
  int failures = 0;

  item_t      qm[$];
  item_t      ql[$];
  item_t      q1[$];
  logic [7:0] log_m[$];
  logic [7:0] log_l[$];
  logic [7:0] log_1[$];

  logic main_ohs = 1'b0, main_ihs = 1'b0;
  logic one_ohs = 1'b0, one_ihs = 1'b0;

  always #5 clk = ~clk;

  flat_bus_serializer #(.CHUNK_W(4), .NCHUNK(3), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(m_rdy), .in_flat(flat),
    .out_valid(m_vld), .out_ready(ordy), .out_chunk(m_chunk), .out_idx(m_idx),
    .out_last(m_last)
  );

  flat_bus_serializer #(.CHUNK_W(4), .NCHUNK(3), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(l_rdy), .in_flat(flat),
    .out_valid(l_vld), .out_ready(ordy), .out_chunk(l_chunk), .out_idx(l_idx),
    .out_last(l_last)
  );

  flat_bus_serializer #(.CHUNK_W(8), .NCHUNK(1), .MSB_FIRST(1)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(o_rdy), .in_flat(flat1),
    .out_valid(o_vld), .out_ready(ordy1), .out_chunk(o_chunk), .out_idx(o_idx),
    .out_last(o_last)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle check of one instance against the head of its expected queue.
  task automatic chk_port(input string nm, input int qsz, input item_t head,
                          input logic ordy_v, input logic vld, input logic rdy,
                          input logic [7:0] ch, input logic [1:0] idx,
                          input logic last);
    logic exp_vld;
    logic exp_rdy;
    exp_vld = (qsz != 0);
    exp_rdy = (qsz == 0) || (qsz == 1 && ordy_v);
    chk({nm, " out_valid"}, 32'(vld), 32'(exp_vld));
    chk({nm, " in_ready"}, 32'(rdy), 32'(exp_rdy));
    if (exp_vld) begin
      chk({nm, " out_chunk"}, 32'(ch), 32'(head.chunk));
      chk({nm, " out_idx"}, 32'(idx), 32'(head.idx));
      chk({nm, " out_last"}, 32'(last), 32'(head.last));
    end else begin
      chk({nm, " out_last idle"}, 32'(last), 32'd0);
    end
  endtask

  task automatic chk_reset(input string nm, input logic vld, input logic rdy,
                           input logic [7:0] ch, input logic [1:0] idx,
                           input logic last);
    chk({nm, " rst out_valid"}, 32'(vld), 32'd0);
    chk({nm, " rst in_ready"}, 32'(rdy), 32'd1);
    chk({nm, " rst out_chunk"}, 32'(ch), 32'd0);
    chk({nm, " rst out_idx"}, 32'(idx), 32'd0);
    chk({nm, " rst out_last"}, 32'(last), 32'd0);
  endtask

  // Compare process: sample away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      qm.delete(); ql.delete(); q1.delete();
      main_ohs <= 1'b0; main_ihs <= 1'b0;
      one_ohs  <= 1'b0; one_ihs  <= 1'b0;
      chk_reset("msb", m_vld, m_rdy, 8'(m_chunk), m_idx, m_last);
      chk_reset("lsb", l_vld, l_rdy, 8'(l_chunk), l_idx, l_last);
      chk_reset("one", o_vld, o_rdy, o_chunk, 2'(o_idx), o_last);
    end else begin
      chk_port("msb", qm.size(), (qm.size() != 0) ? qm[0] : '0, ordy,
               m_vld, m_rdy, 8'(m_chunk), m_idx, m_last);
      chk_port("lsb", ql.size(), (ql.size() != 0) ? ql[0] : '0, ordy,
               l_vld, l_rdy, 8'(l_chunk), l_idx, l_last);
      chk_port("one", q1.size(), (q1.size() != 0) ? q1[0] : '0, ordy1,
               o_vld, o_rdy, o_chunk, 2'(o_idx), o_last);
      main_ohs <= (qm.size() != 0) && ordy;
      main_ihs <= iv && ((qm.size() == 0) || (qm.size() == 1 && ordy));
      one_ohs  <= (q1.size() != 0) && ordy1;
      one_ihs  <= iv1 && ((q1.size() == 0) || (q1.size() == 1 && ordy1));
    end
  end

  // Model update: pop emitted chunks, expand accepted words into chunks.
  always @(posedge clk) begin
    if (rst_n) begin
      if (main_ohs) begin
        log_m.push_back(qm[0].chunk); qm.pop_front();
        log_l.push_back(ql[0].chunk); ql.pop_front();
      end
      if (main_ihs) begin
        for (int i = 0; i < 3; i++) begin
          item_t a;
          item_t b;
          a.chunk = 8'((flat >> (4 * (2 - i))) & 12'hF);
          b.chunk = 8'((flat >> (4 * i)) & 12'hF);
          a.idx = 2'(i); b.idx = 2'(i);
          a.last = (i == 2); b.last = (i == 2);
          qm.push_back(a);
          ql.push_back(b);
        end
      end
      if (one_ohs) begin
        log_1.push_back(q1[0].chunk); q1.pop_front();
      end
      if (one_ihs) begin
        item_t c;
        c.chunk = flat1; c.idx = 2'd0; c.last = 1'b1;
        q1.push_back(c);
      end
    end
  end

  task automatic step(input logic a_iv, input logic [11:0] a_flat, input logic a_ordy,
                      input logic b_iv, input logic [7:0] b_flat, input logic b_ordy);
    iv = a_iv; flat = a_flat; ordy = a_ordy;
    iv1 = b_iv; flat1 = b_flat; ordy1 = b_ordy;
    @(posedge clk); #1;
  endtask

  task automatic mstep(input logic a_iv, input logic [11:0] a_flat, input logic a_ordy);
    step(a_iv, a_flat, a_ordy, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic clear_logs();
    log_m.delete(); log_l.delete(); log_1.delete();
  endtask

  task automatic chk_log(input string nm, input int sel, input logic [7:0] e [6], input int n);
    int got;
    got = (sel == 0) ? log_m.size() : (sel == 1) ? log_l.size() : log_1.size();
    chk({nm, " count"}, 32'(got), 32'(n));
    for (int i = 0; i < n && i < got; i++) begin
      logic [7:0] a;
      a = (sel == 0) ? log_m[i] : (sel == 1) ? log_l[i] : log_1[i];
      chk({nm, " chunk"}, 32'(a), 32'(e[i]));
    end
  endtask

  initial begin
    logic [7:0] es [6];

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready literal", 32'(m_rdy), 32'd1);
    chk("reset out_valid literal", 32'(m_vld), 32'd0);
    rst_n = 1'b1;

    // ABC, out_ready held high
    clear_logs();
    mstep(1'b1, 12'hABC, 1'b1);
    chk("abc first chunk A", 32'(m_chunk), 32'hA);
    chk("abc lsb first chunk C", 32'(l_chunk), 32'hC);
    repeat (4) mstep(1'b0, 12'h000, 1'b1);
    es = '{8'hA, 8'hB, 8'hC, 8'h0, 8'h0, 8'h0};
    chk_log("abc msb", 0, es, 3);
    es = '{8'hC, 8'hB, 8'hA, 8'h0, 8'h0, 8'h0};
    chk_log("abc lsb", 1, es, 3);

    // ABC with a 3-cycle stall on chunk B
    clear_logs();
    mstep(1'b1, 12'hABC, 1'b1);
    mstep(1'b0, 12'h000, 1'b1);
    repeat (3) begin
      mstep(1'b1, 12'hFFF, 1'b0);
      chk("stall chunk B", 32'(m_chunk), 32'hB);
      chk("stall idx 1", 32'(m_idx), 32'd1);
    end
    repeat (3) mstep(1'b0, 12'h000, 1'b1);
    es = '{8'hA, 8'hB, 8'hC, 8'h0, 8'h0, 8'h0};
    chk_log("stall msb", 0, es, 3);

    // 123 waiting with in_valid high throughout ABC
    clear_logs();
    mstep(1'b1, 12'hABC, 1'b1);
    repeat (3) mstep(1'b1, 12'h123, 1'b1);
    repeat (4) mstep(1'b0, 12'h000, 1'b1);
    es = '{8'hA, 8'hB, 8'hC, 8'h1, 8'h2, 8'h3};
    chk_log("b2b msb", 0, es, 6);

    // Reset pulse after chunk A
    clear_logs();
    mstep(1'b1, 12'hABC, 1'b1);
    mstep(1'b0, 12'h000, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(m_vld), 32'd0);
    chk("midreset in_ready", 32'(m_rdy), 32'd1);
    repeat (2) mstep(1'b0, 12'h000, 1'b1);
    rst_n = 1'b1;
    mstep(1'b1, 12'h456, 1'b1);
    repeat (4) mstep(1'b0, 12'h000, 1'b1);
    es = '{8'hA, 8'h4, 8'h5, 8'h6, 8'h0, 8'h0};
    chk_log("reset msb", 0, es, 4);

    // Single-chunk instance, back-to-back words
    clear_logs();
    step(1'b0, 12'h000, 1'b1, 1'b1, 8'h5A, 1'b1);
    chk("one 5A", 32'(o_chunk), 32'h5A);
    step(1'b0, 12'h000, 1'b1, 1'b1, 8'hC3, 1'b1);
    chk("one C3", 32'(o_chunk), 32'hC3);
    chk("one C3 last", 32'(o_last), 32'd1);
    step(1'b0, 12'h000, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 12'h000, 1'b1, 1'b0, 8'h00, 1'b1);
    es = '{8'h5A, 8'hC3, 8'h00, 8'h0, 8'h0, 8'h0};
    chk_log("one seq", 2, es, 2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        step(1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 9) < 6, 12'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 7);
    end
    step(1'b0, 12'h000, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
